// File: rtl/mips_cpu_pkg.sv
// Shared MIPS CPU types and constants: fetch FSM states, reset vector and NOP encoding.
package mips_cpu_pkg;

   typedef enum logic [1:0] {
      S_IDLE,
      S_FETCH,
      S_VALID
   } ifetch_state_t;

   localparam logic [31:0] RESET_VECTOR = 32'hBFC00000;
   localparam logic [31:0] NOP_WORD     = 32'h00000000;

   function automatic logic [31:0] word_align(input logic [31:0] addr);
      return {addr[31:2], 2'b00};
   endfunction

endpackage

// File: rtl/mips_cpu_ifetch.sv
// Instruction fetch: one Avalon-MM read per PC, held for decode under valid/ready.
// Optional misaligned-PC fault detection is built when IFETCH_ALIGN_CHECK_EN is defined.
module mips_cpu_ifetch
   import mips_cpu_pkg::*;
#(
   parameter logic [31:0] RESET_VECTOR = mips_cpu_pkg::RESET_VECTOR,
   parameter logic [31:0] NOP_WORD     = mips_cpu_pkg::NOP_WORD
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] pc,
   input  logic        flush,
   output logic [31:0] imem_address,
   output logic        imem_read,
   output logic [3:0]  imem_byteenable,
   input  logic        imem_waitrequest,
   input  logic [31:0] imem_readdata,
   output logic [31:0] instr,
   output logic [31:0] instr_pc,
   output logic        instr_valid,
   input  logic        instr_ready,
   output logic        pc_advance,
   output logic        fetch_fault
);

   ifetch_state_t state;
   logic          drop_q;
   logic          fault_q;
   logic          misaligned;

`ifdef IFETCH_ALIGN_CHECK_EN
   assign misaligned = |pc[1:0];
`else
   logic unused_pc_low;
   assign unused_pc_low = ^pc[1:0];
   assign misaligned    = 1'b0;
`endif

   assign imem_address    = word_align(pc);
   assign imem_byteenable = 4'b1111;
   assign imem_read       = (state == S_FETCH) && !misaligned;
   assign instr_valid     = (state == S_VALID);
   assign pc_advance      = instr_valid && instr_ready && !flush;
   assign fetch_fault     = fault_q;

   always_ff @(posedge clk) begin
      if (reset) begin
         state    <= S_IDLE;
         instr    <= NOP_WORD;
         instr_pc <= RESET_VECTOR;
         drop_q   <= 1'b0;
         fault_q  <= 1'b0;
      end else begin
         unique case (state)
            S_IDLE: state <= S_FETCH;
            S_FETCH: begin
               if (misaligned) begin
                  // No bus cycle is started, so a flush simply retries at the current pc.
                  drop_q <= 1'b0;
                  if (!flush) begin
                     state    <= S_VALID;
                     instr    <= NOP_WORD;
                     instr_pc <= pc;
                     fault_q  <= 1'b1;
                  end
               end else if (!imem_waitrequest) begin
                  drop_q <= 1'b0;
                  if (!drop_q && !flush) begin
                     state    <= S_VALID;
                     instr    <= imem_readdata;
                     instr_pc <= imem_address;
                  end
               end else if (flush) begin
                  // An Avalon read cannot be aborted; remember to discard its data.
                  drop_q <= 1'b1;
               end
            end
            S_VALID: begin
               if (flush) begin
                  state   <= S_FETCH;
                  instr   <= NOP_WORD;
                  fault_q <= 1'b0;
               end else if (instr_ready) begin
                  state   <= S_FETCH;
                  fault_q <= 1'b0;
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_mips_cpu_ifetch.sv
// Directed bench for mips_cpu_ifetch; the PC register is emulated by the stimulus sequence.
module tb_mips_cpu_ifetch;

   logic        clk = 1'b0;
   logic        reset;
   logic [31:0] pc;
   logic        flush;
   logic [31:0] imem_address;
   logic        imem_read;
   logic [3:0]  imem_byteenable;
   logic        imem_waitrequest;
   logic [31:0] imem_readdata;
   logic [31:0] instr;
   logic [31:0] instr_pc;
   logic        instr_valid;
   logic        instr_ready;
   logic        pc_advance;
   logic        fetch_fault;

   int tests = 0;
   int fails = 0;

   always #5 clk = ~clk;

   mips_cpu_ifetch dut (
      .clk              (clk),
      .reset            (reset),
      .pc               (pc),
      .flush            (flush),
      .imem_address     (imem_address),
      .imem_read        (imem_read),
      .imem_byteenable  (imem_byteenable),
      .imem_waitrequest (imem_waitrequest),
      .imem_readdata    (imem_readdata),
      .instr            (instr),
      .instr_pc         (instr_pc),
      .instr_valid      (instr_valid),
      .instr_ready      (instr_ready),
      .pc_advance       (pc_advance),
      .fetch_fault      (fetch_fault)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Advance to just after the next rising edge; inputs are then set, and checks follow #1 later.
   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   initial begin
      reset            = 1'b1;
      pc               = 32'hBFC00000;
      flush            = 1'b0;
      imem_waitrequest = 1'b0;
      imem_readdata    = 32'h24020005;
      instr_ready      = 1'b1;
      cyc();
      cyc();
      #1;
      chk("rst_valid", {31'd0, instr_valid}, 32'd0);
      chk("rst_read", {31'd0, imem_read}, 32'd0);
      chk("rst_instr", instr, 32'h00000000);
      chk("rst_instr_pc", instr_pc, 32'hBFC00000);
      chk("rst_fault", {31'd0, fetch_fault}, 32'd0);
      chk("byteenable", {28'd0, imem_byteenable}, 32'hF);

      // 1: zero-wait fetch
      reset = 1'b0;
      #1;
      chk("t1_idle_read", {31'd0, imem_read}, 32'd0);
      cyc(); #1;
      chk("t1_read", {31'd0, imem_read}, 32'd1);
      chk("t1_addr", imem_address, 32'hBFC00000);
      chk("t1_not_valid", {31'd0, instr_valid}, 32'd0);
      cyc(); #1;
      chk("t1_valid", {31'd0, instr_valid}, 32'd1);
      chk("t1_instr", instr, 32'h24020005);
      chk("t1_instr_pc", instr_pc, 32'hBFC00000);
      chk("t1_read_off", {31'd0, imem_read}, 32'd0);
      chk("t1_advance", {31'd0, pc_advance}, 32'd1);

      // 2: three wait cycles
      cyc();
      pc               = 32'hBFC00004;
      imem_waitrequest = 1'b1;
      imem_readdata    = 32'h3C010001;
      for (int i = 0; i < 3; i++) begin
         #1;
         chk("t2_wait_read", {31'd0, imem_read}, 32'd1);
         chk("t2_wait_addr", imem_address, 32'hBFC00004);
         chk("t2_wait_valid", {31'd0, instr_valid}, 32'd0);
         if (i < 2) cyc();
      end
      cyc();
      imem_waitrequest = 1'b0;
      #1;
      chk("t2_done_read", {31'd0, imem_read}, 32'd1);
      chk("t2_done_valid", {31'd0, instr_valid}, 32'd0);

      // 3: decode stalls for four cycles
      cyc();
      instr_ready   = 1'b0;
      imem_readdata = 32'hFFFFFFFF;
      for (int i = 0; i < 4; i++) begin
         #1;
         chk("t3_valid", {31'd0, instr_valid}, 32'd1);
         chk("t3_instr", instr, 32'h3C010001);
         chk("t3_instr_pc", instr_pc, 32'hBFC00004);
         chk("t3_no_adv", {31'd0, pc_advance}, 32'd0);
         chk("t3_no_read", {31'd0, imem_read}, 32'd0);
         cyc();
      end
      instr_ready = 1'b1;
      #1;
      chk("t3_advance", {31'd0, pc_advance}, 32'd1);

      // 4: flush while the bus is stalled
      cyc();
      pc               = 32'hBFC00008;
      imem_waitrequest = 1'b1;
      imem_readdata    = 32'hDEADBEEF;
      flush            = 1'b1;
      #1;
      chk("t4_read", {31'd0, imem_read}, 32'd1);
      chk("t4_addr", imem_address, 32'hBFC00008);
      cyc();
      flush = 1'b0;
      cyc();
      imem_waitrequest = 1'b0;
      #1;
      chk("t4_stale_read", {31'd0, imem_read}, 32'd1);
      cyc();
      imem_readdata = 32'h00851020;
      #1;
      chk("t4_drop_valid", {31'd0, instr_valid}, 32'd0);
      chk("t4_reissue", {31'd0, imem_read}, 32'd1);
      chk("t4_reissue_addr", imem_address, 32'hBFC00008);
      cyc();
      #1;
      chk("t4_valid", {31'd0, instr_valid}, 32'd1);
      chk("t4_instr", instr, 32'h00851020);
      chk("t4_instr_pc", instr_pc, 32'hBFC00008);

      // 5: flush beats ready
      flush = 1'b1;
      #1;
      chk("t5_no_adv", {31'd0, pc_advance}, 32'd0);
      cyc();
      flush         = 1'b0;
      imem_readdata = 32'hAC020000;
      #1;
      chk("t5_valid_drop", {31'd0, instr_valid}, 32'd0);
      chk("t5_nop", instr, 32'h00000000);
      chk("t5_refetch", {31'd0, imem_read}, 32'd1);
      chk("t5_refetch_addr", imem_address, 32'hBFC00008);
      cyc();
      #1;
      chk("t5_instr", instr, 32'hAC020000);
      chk("t5_instr_pc", instr_pc, 32'hBFC00008);
      chk("t5_advance", {31'd0, pc_advance}, 32'd1);

      // Reset in the middle of a stalled read
      cyc();
      pc               = 32'hBFC0000C;
      imem_waitrequest = 1'b1;
      #1;
      chk("rst_mid_read", {31'd0, imem_read}, 32'd1);
      reset = 1'b1;
      cyc();
      pc = 32'hBFC00000;
      #1;
      chk("rst_mid_read_off", {31'd0, imem_read}, 32'd0);
      chk("rst_mid_valid", {31'd0, instr_valid}, 32'd0);
      chk("rst_mid_instr", instr, 32'h00000000);
      chk("rst_mid_instr_pc", instr_pc, 32'hBFC00000);

      // 6: misaligned pc
      reset            = 1'b0;
      imem_waitrequest = 1'b0;
      imem_readdata    = 32'h12345678;
      pc               = 32'hBFC00002;
      cyc();
      #1;
`ifdef IFETCH_ALIGN_CHECK_EN
      chk("t6_no_read", {31'd0, imem_read}, 32'd0);
      cyc();
      #1;
      chk("t6_valid", {31'd0, instr_valid}, 32'd1);
      chk("t6_fault", {31'd0, fetch_fault}, 32'd1);
      chk("t6_nop", instr, 32'h00000000);
      chk("t6_instr_pc", instr_pc, 32'hBFC00002);
      chk("t6_advance", {31'd0, pc_advance}, 32'd1);
      cyc();
      #1;
      chk("t6_fault_clr", {31'd0, fetch_fault}, 32'd0);
`else
      chk("t6_read", {31'd0, imem_read}, 32'd1);
      chk("t6_addr_aligned", imem_address, 32'hBFC00000);
      cyc();
      #1;
      chk("t6_valid", {31'd0, instr_valid}, 32'd1);
      chk("t6_instr", instr, 32'h12345678);
      chk("t6_instr_pc", instr_pc, 32'hBFC00000);
      chk("t6_no_fault", {31'd0, fetch_fault}, 32'd0);
`endif

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
